// File: rtl/control_fsm_pkg.sv
// Shared control-state encodings and opcode class constants for the multi-cycle
// controller and the downstream control-decode stage.
package control_fsm_pkg;

    typedef enum logic [3:0] {
        INSTRUCTION_FETCH    = 4'd0,
        REGISTER_FETCH       = 4'd1,
        ALU_R3               = 4'd2,
        ALU_RI3              = 4'd3,
        ALU_WB4              = 4'd4,
        BRANCH3              = 4'd5,
        MEM_REF3             = 4'd6,
        LOAD4                = 4'd7,
        STORE4               = 4'd8,
        LOAD5                = 4'd9,
        JUMP3                = 4'd10,
        IMMEDIATE_INJECTION2 = 4'd11,
        HALT                 = 4'd12
    } state_t;

    localparam logic [5:0] OP_LOAD   = 6'b100000;
    localparam logic [5:0] OP_STORE  = 6'b100001;
    localparam logic [5:0] OP_BRANCH = 6'b100010;
    localparam logic [5:0] OP_JUMP   = 6'b100011;
    localparam logic [5:0] OP_LI     = 6'b110000;
    localparam logic [5:0] OP_HALT   = 6'b111111;

    // Bit positions in the one-hot opcode class vector
    localparam int CLS_R       = 0;
    localparam int CLS_RI      = 1;
    localparam int CLS_LOAD    = 2;
    localparam int CLS_STORE   = 3;
    localparam int CLS_BRANCH  = 4;
    localparam int CLS_JUMP    = 5;
    localparam int CLS_LI      = 6;
    localparam int CLS_HALT    = 7;
    localparam int CLS_ILLEGAL = 8;
    localparam int CLS_W       = 9;

endpackage

// File: rtl/control_fsm_opcode_class.sv
// Combinational opcode classifier: exactly one bit of cls is set for any opcode.
module opcode_class
    import control_fsm_pkg::*;
(
    input  logic [5:0]       opcode,
    output logic [CLS_W-1:0] cls
);

    always_comb begin
        cls = '0;
        if (opcode[5:4] == 2'b00) begin
            cls[CLS_R] = 1'b1;
        end else if (opcode[5:4] == 2'b01) begin
            cls[CLS_RI] = 1'b1;
        end else begin
            case (opcode)
                OP_LOAD:   cls[CLS_LOAD]    = 1'b1;
                OP_STORE:  cls[CLS_STORE]   = 1'b1;
                OP_BRANCH: cls[CLS_BRANCH]  = 1'b1;
                OP_JUMP:   cls[CLS_JUMP]    = 1'b1;
                OP_LI:     cls[CLS_LI]      = 1'b1;
                OP_HALT:   cls[CLS_HALT]    = 1'b1;
                default:   cls[CLS_ILLEGAL] = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle processor control FSM with retired-instruction counter and a
// sticky illegal-opcode flag.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int RETIRE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              opcode,
    input  logic                    mem_ready,
    output logic [3:0]              state,
    output logic                    instr_retired,
    output logic [RETIRE_CNT_W-1:0] retired_count,
    output logic                    illegal_op,
    output logic                    halted
);

    state_t                  state_reg;
    logic                    retired_reg;
    logic [RETIRE_CNT_W-1:0] count_reg;
    logic                    illegal_reg;
    logic [CLS_W-1:0]        cls;
    logic                    done;

    opcode_class u_opcode_class (
        .opcode (opcode),
        .cls    (cls)
    );

    // Instruction completes on this edge; HALT entry counts as a completion
    always_comb begin
        done = 1'b0;
        case (state_reg)
            ALU_WB4, BRANCH3, JUMP3, IMMEDIATE_INJECTION2, LOAD5: done = 1'b1;
            STORE4:         done = mem_ready;
            REGISTER_FETCH: done = cls[CLS_HALT];
            default:        done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= INSTRUCTION_FETCH;
            retired_reg <= 1'b0;
            count_reg   <= '0;
            illegal_reg <= 1'b0;
        end else begin
            retired_reg <= done;
            if (done) begin
                count_reg <= count_reg + RETIRE_CNT_W'(1);
            end
            case (state_reg)
                INSTRUCTION_FETCH: begin
                    if (mem_ready) state_reg <= REGISTER_FETCH;
                end
                REGISTER_FETCH: begin
                    if (cls[CLS_R])                          state_reg <= ALU_R3;
                    else if (cls[CLS_RI])                    state_reg <= ALU_RI3;
                    else if (cls[CLS_LOAD] || cls[CLS_STORE]) state_reg <= MEM_REF3;
                    else if (cls[CLS_BRANCH])                state_reg <= BRANCH3;
                    else if (cls[CLS_JUMP])                  state_reg <= JUMP3;
                    else if (cls[CLS_LI])                    state_reg <= IMMEDIATE_INJECTION2;
                    else if (cls[CLS_HALT])                  state_reg <= HALT;
                    else if (cls[CLS_ILLEGAL]) begin
                        state_reg   <= INSTRUCTION_FETCH;
                        illegal_reg <= 1'b1;
                    end else begin
                        state_reg <= INSTRUCTION_FETCH;
                    end
                end
                ALU_R3, ALU_RI3: state_reg <= ALU_WB4;
                // An opcode that is neither LOAD nor STORE here abandons the access
                MEM_REF3: begin
                    if (cls[CLS_LOAD])       state_reg <= LOAD4;
                    else if (cls[CLS_STORE]) state_reg <= STORE4;
                    else                     state_reg <= INSTRUCTION_FETCH;
                end
                LOAD4: begin
                    if (mem_ready) state_reg <= LOAD5;
                end
                STORE4: begin
                    if (mem_ready) state_reg <= INSTRUCTION_FETCH;
                end
                ALU_WB4, BRANCH3, JUMP3, IMMEDIATE_INJECTION2, LOAD5:
                    state_reg <= INSTRUCTION_FETCH;
                HALT: state_reg <= HALT;
                default: state_reg <= INSTRUCTION_FETCH;
            endcase
        end
    end

    assign state         = state_reg;
    assign instr_retired = retired_reg;
    assign retired_count = count_reg;
    assign illegal_op    = illegal_reg;
    assign halted        = (state_reg == HALT);

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm built with a 4-bit retire counter so the
// counter wrap is reachable in a short run.
module tb_control_fsm;

    localparam int CW = 4;

    localparam logic [5:0] R_OP   = 6'b000010;
    localparam logic [5:0] RI_OP  = 6'b010111;
    localparam logic [5:0] LD_OP  = 6'b100000;
    localparam logic [5:0] ST_OP  = 6'b100001;
    localparam logic [5:0] BR_OP  = 6'b100010;
    localparam logic [5:0] JP_OP  = 6'b100011;
    localparam logic [5:0] LI_OP  = 6'b110000;
    localparam logic [5:0] HLT_OP = 6'b111111;
    localparam logic [5:0] BAD_OP = 6'b101010;

    localparam int S_IF = 0, S_RF = 1, S_R3 = 2, S_RI3 = 3, S_WB4 = 4, S_BR3 = 5,
                   S_MEM3 = 6, S_LD4 = 7, S_ST4 = 8, S_LD5 = 9, S_JP3 = 10,
                   S_LI2 = 11, S_HLT = 12;

    logic          clk;
    logic          reset;
    logic [5:0]    opcode;
    logic          mem_ready;
    logic [3:0]    state;
    logic          instr_retired;
    logic [CW-1:0] retired_count;
    logic          illegal_op;
    logic          halted;

    typedef struct {
        int st;
        int ret;
        int cnt;
        int ill;
        int hlt;
    } exp_t;

    exp_t          sb[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [CW-1:0] exp_cnt = '0;
    int            exp_ill = 0;

    control_fsm #(.RETIRE_CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .state         (state),
        .instr_retired (instr_retired),
        .retired_count (retired_count),
        .illegal_op    (illegal_op),
        .halted        (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_now(input int st, input int ret);
        exp_t e;
        e.st  = st;
        e.ret = ret;
        e.cnt = int'(exp_cnt);
        e.ill = exp_ill;
        e.hlt = (st == S_HLT) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".state"},   32'(state),         32'(e.st));
            chk({tag, ".retired"}, 32'(instr_retired), 32'(e.ret));
            chk({tag, ".count"},   32'(retired_count), 32'(e.cnt));
            chk({tag, ".illegal"}, 32'(illegal_op),    32'(e.ill));
            chk({tag, ".halted"},  32'(halted),        32'(e.hlt));
        end
    endtask

    // Drive inputs for one edge, then compare what the DUT shows after it
    task automatic step(input string tag, input logic [5:0] op, input logic mr,
                        input int st, input int ret);
        opcode    = op;
        mem_ready = mr;
        if (ret != 0) exp_cnt = exp_cnt + 1'b1;
        expect_now(st, ret);
        @(posedge clk);
        @(negedge clk);
        compare_out(tag);
    endtask

    task automatic run3(input string tag, input logic [5:0] op, input int mid);
        step(tag, op, 1'b1, S_RF, 0);
        step(tag, op, 1'b1, mid, 0);
        step(tag, op, 1'b1, S_IF, 1);
        $display("instr %s op=%b count=%0d", tag, op, retired_count);
    endtask

    task automatic run4(input string tag, input logic [5:0] op, input int s3);
        step(tag, op, 1'b1, S_RF, 0);
        step(tag, op, 1'b1, s3, 0);
        step(tag, op, 1'b1, S_WB4, 0);
        step(tag, op, 1'b1, S_IF, 1);
        $display("instr %s op=%b count=%0d", tag, op, retired_count);
    endtask

    // Assert reset mid-cycle and check outputs clear before the next edge
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        exp_cnt = '0;
        exp_ill = 0;
        expect_now(S_IF, 0);
        compare_out(tag);
        @(negedge clk);
        reset = 1'b0;
        $display("reset %s", tag);
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'd0;
        mem_ready = 1'b0;
        @(negedge clk);
        expect_now(S_IF, 0);
        compare_out("reset_state");
        reset = 1'b0;

        // IF waits on mem_ready, then R-type: 0,1,2,4,0
        step("if_wait", R_OP, 1'b0, S_IF, 0);
        step("if_wait", R_OP, 1'b0, S_IF, 0);
        run4("r_type", R_OP, S_R3);
        chk("r_type.count1", 32'(retired_count), 32'd1);

        // LOAD with three wait cycles: 0,1,6,7,7,7,7,9,0
        step("load", LD_OP, 1'b1, S_RF, 0);
        step("load", LD_OP, 1'b0, S_MEM3, 0);
        step("load", LD_OP, 1'b0, S_LD4, 0);
        for (int i = 0; i < 3; i++) step("load_wait", LD_OP, 1'b0, S_LD4, 0);
        step("load", LD_OP, 1'b1, S_LD5, 0);
        step("load", LD_OP, 1'b1, S_IF, 1);
        $display("instr load op=%b count=%0d", LD_OP, retired_count);

        // Illegal opcode: 0,1,0, flag sticky, nothing retired
        step("illegal", BAD_OP, 1'b1, S_RF, 0);
        exp_ill = 1;
        step("illegal", BAD_OP, 1'b1, S_IF, 0);
        $display("instr illegal op=%b count=%0d", BAD_OP, retired_count);

        // STORE with no wait, flag must stay set
        step("store", ST_OP, 1'b1, S_RF, 0);
        step("store", ST_OP, 1'b1, S_MEM3, 0);
        step("store", ST_OP, 1'b1, S_ST4, 0);
        step("store", ST_OP, 1'b1, S_IF, 1);
        $display("instr store op=%b count=%0d", ST_OP, retired_count);

        run3("branch", BR_OP, S_BR3);
        run3("jump", JP_OP, S_JP3);
        run3("li", LI_OP, S_LI2);
        run4("ri_type", RI_OP, S_RI3);

        // HALT is terminal regardless of inputs; entry retires once
        step("halt", HLT_OP, 1'b1, S_RF, 0);
        step("halt", HLT_OP, 1'b1, S_HLT, 1);
        for (int i = 0; i < 20; i++)
            step("halt_hold", 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), S_HLT, 0);
        $display("instr halt op=%b count=%0d", HLT_OP, retired_count);
        async_reset("reset_from_halt");

        // Set the flag, then reset during a STORE4 wait
        step("illegal2", BAD_OP, 1'b1, S_RF, 0);
        exp_ill = 1;
        step("illegal2", BAD_OP, 1'b1, S_IF, 0);
        step("store_wait", ST_OP, 1'b1, S_RF, 0);
        step("store_wait", ST_OP, 1'b0, S_MEM3, 0);
        step("store_wait", ST_OP, 1'b0, S_ST4, 0);
        step("store_wait", ST_OP, 1'b0, S_ST4, 0);
        async_reset("reset_in_store4");

        // Counter wrap: 2^CW-1 LI instructions reach all-ones, next one gives 0
        for (int i = 0; i < (1 << CW) - 1; i++) run3("li_fill", LI_OP, S_LI2);
        chk("wrap.all_ones", 32'(retired_count), 32'((1 << CW) - 1));
        run3("li_wrap", LI_OP, S_LI2);
        chk("wrap.zero", 32'(retired_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
